// File: rtl/multdiv_pkg.sv
// Shared encodings for the multicycle multiply/divide sequencing controller.
package multdiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int ITER_MULT_DEF = 32;
  localparam int ITER_DIV_DEF  = 32;

endpackage

// File: rtl/iter_counter.sv
// Iteration index counter: sync clear, increment enable, terminal-count compare
// against a limit supplied at runtime.
module iter_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == limit_i);

  // Holding at terminal count keeps the counter from ever wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// Control sequencer for the multicycle multiply/divide unit: drives datapath
// enables, iteration index and pipeline stall; flags divide-by-zero.
//
// state | meaning
// IDLE  | waiting for start_mult / start_div
// LOAD  | latch operands, clear accumulator, check divisor
// RUN   | one accumulator step per cycle, step = iteration index
// WRITE | capture result register
// DONE  | result_rdy pulse (with exception), may chain directly into LOAD
module multdiv_seq_ctrl
  import multdiv_pkg::*;
#(
  parameter int ITER_MULT = ITER_MULT_DEF,
  parameter int ITER_DIV  = ITER_DIV_DEF,
  parameter int CNT_W     = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             divisor_zero,
  input  logic             flush,
  output logic             op_reg_en,
  output logic             acc_init,
  output logic             acc_en,
  output logic             res_en,
  output logic [CNT_W-1:0] step,
  output logic             is_div,
  output logic             busy,
  output logic             result_rdy,
  output logic             exception
);

  localparam logic [CNT_W-1:0] LIM_MULT = CNT_W'(ITER_MULT - 1);
  localparam logic [CNT_W-1:0] LIM_DIV  = CNT_W'(ITER_DIV - 1);

  state_e           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             exc_q, exc_d;
  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic             start_any;
  logic             op_sel;

  assign start_any = start_mult | start_div;
  // Multiply wins when both requests arrive together.
  assign op_sel    = (start_div & ~start_mult) ? OP_DIV : OP_MULT;

  iter_counter #(.CNT_W(CNT_W)) u_iter_counter (
    .clk     (clk),
    .clr     (clr),
    .clear_i ((state_q != ST_RUN) | flush),
    .inc_i   (state_q == ST_RUN),
    .limit_i (is_div_q ? LIM_DIV : LIM_MULT),
    .cnt_o   (cnt),
    .tc_o    (tc)
  );

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    exc_d    = exc_q;
    case (state_q)
      ST_IDLE: begin
        if (start_any && !flush) begin
          state_d  = ST_LOAD;
          is_div_d = op_sel;
        end
      end
      ST_LOAD: begin
        if (is_div_q && divisor_zero) begin
          state_d = ST_DONE;
          exc_d   = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tc) state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE: begin
        exc_d = 1'b0;
        if (start_any && !flush) begin
          state_d  = ST_LOAD;
          is_div_d = op_sel;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort from any busy state; suppresses the downstream write and ready.
    if (flush && (state_q == ST_LOAD || state_q == ST_RUN || state_q == ST_WRITE)) begin
      state_d = ST_IDLE;
      exc_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q  <= ST_IDLE;
      is_div_q <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      exc_q    <= exc_d;
    end
  end

  assign op_reg_en  = (state_q == ST_LOAD);
  assign acc_init   = (state_q == ST_LOAD);
  assign acc_en     = (state_q == ST_RUN);
  assign res_en     = (state_q == ST_WRITE);
  assign step       = (state_q == ST_RUN) ? cnt : '0;
  assign is_div     = is_div_q;
  assign busy       = (state_q == ST_LOAD) | (state_q == ST_RUN) | (state_q == ST_WRITE);
  assign result_rdy = (state_q == ST_DONE);
  assign exception  = (state_q == ST_DONE) & exc_q;

endmodule

// File: doc/multdiv_seq_ctrl.md
Name: multdiv_seq_ctrl

Overview:
- Sequencing controller for the multicycle multiply/divide unit built from 32-bit enable/clear registers: operand latches, iteration accumulator, result register.
- Accepts a start pulse from decode, drives load/step/write enables and the iteration index, and raises a stall to the pipeline while busy.
- Reports completion and divide-by-zero exception.
- No datapath arithmetic inside; only the control state.

Parameters:
- ITER_MULT, 32, iterations per multiply (radix-2 shift-add)
- ITER_DIV, 32, iterations per divide (restoring)
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > max(ITER_MULT, ITER_DIV)

Ports:
- clk  in  1  system clock, all state on rising edge
- clr  in  1  reset, synchronous, active-low
- start_mult  in  1  request multiply, single-cycle pulse from decode
- start_div  in  1  request divide, single-cycle pulse from decode
- divisor_zero  in  1  operand B == 0, from operand-latch side, valid in LOAD
- flush  in  1  abort current operation (pipeline flush / exception)
- op_reg_en  out  1  enable for operand registers A/B
- acc_init  out  1  clear for accumulator register
- acc_en  out  1  enable for accumulator register (one iteration step)
- res_en  out  1  enable for result register
- step  out  CNT_W  current iteration index
- is_div  out  1  latched op type: 1 = divide, 0 = multiply
- busy  out  1  stall request to pipeline
- result_rdy  out  1  result valid pulse
- exception  out  1  divide-by-zero flag, coincident with result_rdy

Behaviour:
- Reset: clr low at a rising edge forces state IDLE, cnt=0, is_div=0. All outputs 0 the cycle after. Reset dominates flush and start.
- All outputs are Moore decodes of registered state/cnt/is_div; no combinational start-to-output path.
- States: IDLE, LOAD, RUN, WRITE, DONE.
- IDLE: start_mult or start_div -> LOAD, latch is_div = start_div & ~start_mult. Both high at once: multiply wins, divide dropped.
- LOAD (1 cycle): op_reg_en=1, acc_init=1, busy=1.
  - If is_div & divisor_zero -> DONE with exc flag set.
  - Otherwise -> RUN with cnt=0.
- RUN: acc_en=1, busy=1, step=cnt, cnt+1 each cycle.
  - When cnt == ITER-1, where ITER = is_div ? ITER_DIV : ITER_MULT -> WRITE.
  - cnt never wraps.
- WRITE (1 cycle): res_en=1, busy=1 -> DONE.
- DONE (1 cycle): result_rdy=1; exception=exc flag; busy=0.
  - exc flag clears on leaving DONE.
  - start in DONE -> LOAD directly (back-to-back), otherwise -> IDLE.
- start in LOAD/RUN/WRITE: ignored; no queueing.
- flush in LOAD/RUN/WRITE:
  - Next state IDLE, cnt=0, exc cleared.
  - Suppresses res_en and result_rdy; the same-cycle enable still follows current state.
  - flush in DONE: result_rdy still shown that cycle, next state IDLE.
  - flush in IDLE: no effect, and start is ignored that cycle.
- Latency, start at edge 0, ITER=32: LOAD cycle 1, RUN cycles 2..33, WRITE 34, result_rdy 35. Divide-by-zero: result_rdy cycle 2.
- step outside RUN: held at 0.

Decomposition:
- Package multdiv_pkg: state encoding (5 states, binary 3-bit), OP_MULT/OP_DIV constants, default ITER values.
- Sub-module iter_counter: CNT_W-bit counter with sync clear, increment enable, and terminal-count compare against a runtime limit input. Instantiated once.

Test Plan:
- Multiply:
  - Stimulus: start_mult pulse at cycle 0.
  - Response: op_reg_en=acc_init=1 at cycle 1; acc_en=1 cycles 2..33 with step 0..31; res_en at 34; result_rdy=1, exception=0 at 35; busy high cycles 1..34 only.
- Divide by zero:
  - Stimulus: start_div with divisor_zero=1.
  - Response: LOAD at cycle 1; result_rdy=exception=1 at cycle 2; acc_en and res_en never asserted.
- Simultaneous start and back-to-back:
  - Stimulus: start_mult=start_div=1, then start_div in the DONE cycle.
  - Response: first op is_div=0; second LOAD the cycle after DONE with is_div=1, no IDLE gap.
- Flush mid-run:
  - Stimulus: flush at step=10.
  - Response: IDLE next cycle; busy=0; no res_en or result_rdy; a new start_mult then completes normally after 35 cycles.
- Reset mid-operation:
  - Stimulus: clr=0 for 1 cycle during RUN with start_mult=1 held.
  - Response: all outputs 0, step=0 after the edge; start ignored while clr low.
- Ignored start:
  - Stimulus: start_div pulse during RUN.
  - Response: no effect; the operation completes with the original is_div and unchanged latency.
